// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two caches, the arbiter and the shared main memory.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 128
);
  // I-cache port
  logic              I_READ;
  logic [ADDR_W-1:0] I_ADDRESS;
  logic [DATA_W-1:0] I_READ_DATA;
  logic              I_BUSY_WAIT;
  // D-cache port
  logic              D_READ;
  logic              D_WRITE;
  logic [ADDR_W-1:0] D_ADDRESS;
  logic [DATA_W-1:0] D_WRITE_DATA;
  logic [DATA_W-1:0] D_READ_DATA;
  logic              D_BUSY_WAIT;
  // Main memory port
  logic              MEM_READ;
  logic              MEM_WRITE;
  logic [ADDR_W-1:0] MEM_ADDRESS;
  logic [DATA_W-1:0] MEM_WRITE_DATA;
  logic [DATA_W-1:0] MEM_READ_DATA;
  logic              MEM_BUSY_WAIT;

  modport slave (
    input  I_READ, I_ADDRESS, D_READ, D_WRITE, D_ADDRESS, D_WRITE_DATA,
    input  MEM_READ_DATA, MEM_BUSY_WAIT,
    output I_READ_DATA, I_BUSY_WAIT, D_READ_DATA, D_BUSY_WAIT,
    output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITE_DATA
  );

  modport master (
    output I_READ, I_ADDRESS, D_READ, D_WRITE, D_ADDRESS, D_WRITE_DATA,
    output MEM_READ_DATA, MEM_BUSY_WAIT,
    input  I_READ_DATA, I_BUSY_WAIT, D_READ_DATA, D_BUSY_WAIT,
    input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITE_DATA
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one block memory between the I-cache (read-only)
// and the D-cache (read/write). Ties alternate; the loser waits one transaction.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 128
) (
  input logic         CLK,
  input logic         RESET,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

  localparam logic OwnI = 1'b0;
  localparam logic OwnD = 1'b1;

  state_t            state;
  logic              owner;
  logic              op_write;
  logic              busy_seen;
  logic              last_grant;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] i_rdata;
  logic [DATA_W-1:0] d_rdata;

  logic i_req;
  logic d_req;
  logic grant_d;

  assign i_req   = bus.I_READ;
  assign d_req   = bus.D_READ | bus.D_WRITE;
  // D wins when alone, or on a tie when I had the previous grant.
  assign grant_d = d_req & (~i_req | (last_grant == OwnI));

  // Arbitration FSM; memory request and responses are registered.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      owner      <= OwnI;
      op_write   <= 1'b0;
      busy_seen  <= 1'b0;
      last_grant <= OwnI;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_req || d_req) begin
            owner      <= grant_d;
            last_grant <= grant_d;
            state      <= GRANT;
            if (grant_d) begin
              // A write takes precedence over a simultaneous read.
              op_write  <= bus.D_WRITE;
              mem_write <= bus.D_WRITE;
              mem_read  <= ~bus.D_WRITE;
              addr      <= bus.D_ADDRESS;
              wdata     <= bus.D_WRITE_DATA;
            end else begin
              op_write  <= 1'b0;
              mem_write <= 1'b0;
              mem_read  <= 1'b1;
              addr      <= bus.I_ADDRESS;
            end
          end
        end
        GRANT: begin
          // Completion is only trusted after memory has shown busy at least once.
          if (bus.MEM_BUSY_WAIT) begin
            busy_seen <= 1'b1;
          end else if (busy_seen) begin
            if (!op_write) begin
              if (owner == OwnD) d_rdata <= bus.MEM_READ_DATA;
              else               i_rdata <= bus.MEM_READ_DATA;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: begin
          busy_seen <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs driven from latched state so requester changes mid-access are ignored.
  always_comb begin
    bus.MEM_READ       = mem_read;
    bus.MEM_WRITE      = mem_write;
    bus.MEM_ADDRESS    = addr;
    bus.MEM_WRITE_DATA = wdata;
    bus.I_READ_DATA    = i_rdata;
    bus.D_READ_DATA    = d_rdata;
    bus.I_BUSY_WAIT    = i_req & ~((state == RESP) & (owner == OwnI));
    bus.D_BUSY_WAIT    = d_req & ~((state == RESP) & (owner == OwnD));
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a latency-modelled memory and a scoreboard
// of expected transactions in service order.
module tb_mem_arbiter;

  localparam int LAT = 5;
  localparam logic [127:0] DeadVal  = 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] WrVal    = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_ABCD;
  localparam logic [127:0] WrVal2   = 128'hCAFE_F00D_1111_2222_3333_4444_5555_6666;

  typedef struct {
    logic         who;   // 1 = D-cache
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] data;  // read data for reads, write data for writes
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cnt;
  int   last_lat;
  int   last_mem_n;
  logic [27:0]  wr_addr;
  logic [127:0] wr_data;
  exp_t sb[$];

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rd(input logic [27:0] a);
    if (a == 28'h4) return DeadVal;
    return {4{4'hA, a}};
  endfunction

  // Memory model: busy for LAT cycles of a held request, then idle with data ready.
  assign bus.MEM_BUSY_WAIT = (bus.MEM_READ | bus.MEM_WRITE) && (cnt < LAT);

  always @(posedge clk) begin
    if (rst) begin
      cnt <= 0;
    end else if (bus.MEM_READ || bus.MEM_WRITE) begin
      if (cnt < LAT) cnt <= cnt + 1;
      if (bus.MEM_WRITE && cnt == LAT) begin
        wr_addr <= bus.MEM_ADDRESS;
        wr_data <= bus.MEM_WRITE_DATA;
      end
    end else begin
      cnt <= 0;
    end
    bus.MEM_READ_DATA <= rd(bus.MEM_ADDRESS);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic who, input logic wr, input logic [27:0] a,
                      input logic [127:0] d);
    exp_t e;
    e.who = who; e.wr = wr; e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  // Pop the next expected transaction and follow it until its response cycle.
  task automatic serve(input string tag);
    exp_t e;
    logic got, seen_mem, other_ok, rd_in_wr, own, oth_req, oth_busy;
    int   n;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    got = 0; seen_mem = 0; other_ok = 1; rd_in_wr = 0; n = 0; last_mem_n = 0;
    while (!got && n < 100) begin
      @(posedge clk); #1; n++;
      if (!seen_mem && (bus.MEM_READ || bus.MEM_WRITE)) begin
        seen_mem   = 1;
        last_mem_n = n;
        chk({tag, " mem_write"}, bus.MEM_WRITE, e.wr);
        chk({tag, " mem_read"}, bus.MEM_READ, !e.wr);
        chk({tag, " mem_addr"}, bus.MEM_ADDRESS, e.addr);
        if (e.wr) chk({tag, " mem_wdata"}, bus.MEM_WRITE_DATA, e.data);
      end
      if (e.wr && bus.MEM_READ) rd_in_wr = 1;
      if (e.who) begin
        own      = (bus.D_READ || bus.D_WRITE) && !bus.D_BUSY_WAIT;
        oth_req  = bus.I_READ;
        oth_busy = bus.I_BUSY_WAIT;
      end else begin
        own      = bus.I_READ && !bus.I_BUSY_WAIT;
        oth_req  = bus.D_READ || bus.D_WRITE;
        oth_busy = bus.D_BUSY_WAIT;
      end
      if (oth_busy !== oth_req) other_ok = 0;
      got = own;
    end
    last_lat = n;
    chk({tag, " resp_seen"}, got, 1);
    chk({tag, " other_busy"}, other_ok, 1);
    if (got) begin
      chk({tag, " resp_mem_idle"}, {bus.MEM_READ, bus.MEM_WRITE}, 0);
      if (e.wr) chk({tag, " no_read_in_write"}, rd_in_wr, 0);
      else if (e.who) chk({tag, " d_rdata"}, bus.D_READ_DATA, e.data);
      else chk({tag, " i_rdata"}, bus.I_READ_DATA, e.data);
    end
  endtask

  initial begin
    logic [1:0] st;
    total = 0; bad = 0;
    rst = 1'b1;
    bus.I_READ = 0; bus.I_ADDRESS = '0;
    bus.D_READ = 0; bus.D_WRITE = 0; bus.D_ADDRESS = '0; bus.D_WRITE_DATA = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    st = dut.state;
    chk("rst state", st, 0);
    chk("rst mem_rw", {bus.MEM_READ, bus.MEM_WRITE}, 0);
    chk("rst busy", {bus.I_BUSY_WAIT, bus.D_BUSY_WAIT}, 0);
    chk("rst i_rdata", bus.I_READ_DATA, 0);
    chk("rst d_rdata", bus.D_READ_DATA, 0);
    rst = 1'b0;

    // I-only read
    bus.I_ADDRESS = 28'h4; bus.I_READ = 1;
    push(0, 0, 28'h4, DeadVal);
    serve("i_only");
    chk("i_only mem_read_delay", last_mem_n, 1);
    chk("i_only latency", last_lat, LAT + 2);
    bus.I_READ = 0;
    @(posedge clk); #1;
    chk("i_only hold", bus.I_READ_DATA, DeadVal);
    st = dut.state;
    chk("i_only idle", st, 0);

    // D write-back
    bus.D_ADDRESS = 28'h10; bus.D_WRITE_DATA = WrVal; bus.D_WRITE = 1;
    push(1, 1, 28'h10, WrVal);
    serve("d_wr");
    bus.D_WRITE = 0;
    @(posedge clk); #1;
    chk("d_wr mem_addr", wr_addr, 28'h10);
    chk("d_wr mem_data", wr_data, WrVal);

    // Both pending from reset, then continuous contention: D, I, D, I
    rst = 1'b1;
    @(posedge clk); #1;
    bus.I_ADDRESS = 28'h20; bus.I_READ = 1;
    bus.D_ADDRESS = 28'h30; bus.D_READ = 1;
    rst = 1'b0;
    push(1, 0, 28'h30, rd(28'h30));
    serve("cont0_d");
    bus.D_ADDRESS = 28'h31;
    push(0, 0, 28'h20, rd(28'h20));
    serve("cont1_i");
    chk("cont1 latency", last_lat, LAT + 3);
    bus.I_ADDRESS = 28'h21;
    push(1, 0, 28'h31, rd(28'h31));
    serve("cont2_d");
    bus.D_READ = 0;
    push(0, 0, 28'h21, rd(28'h21));
    serve("cont3_i");
    bus.I_READ = 0;
    @(posedge clk); #1;

    // D_READ and D_WRITE together decode as a write
    bus.D_ADDRESS = 28'h11; bus.D_WRITE_DATA = WrVal2; bus.D_READ = 1; bus.D_WRITE = 1;
    push(1, 1, 28'h11, WrVal2);
    serve("d_rw");
    bus.D_READ = 0; bus.D_WRITE = 0;
    @(posedge clk); #1;
    chk("d_rw mem_data", wr_data, WrVal2);

    // Reset two cycles into a D read
    bus.D_ADDRESS = 28'h12; bus.D_READ = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid mem_read", bus.MEM_READ, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    st = dut.state;
    chk("mid state", st, 0);
    chk("mid mem_read_rst", bus.MEM_READ, 0);
    chk("mid busy_seen", dut.busy_seen, 0);
    bus.I_ADDRESS = 28'h22; bus.I_READ = 1;
    rst = 1'b0;
    push(1, 0, 28'h12, rd(28'h12));
    serve("mid_d");
    bus.D_READ = 0;
    push(0, 0, 28'h22, rd(28'h22));
    serve("mid_i");
    bus.I_READ = 0;
    @(posedge clk); #1;
    chk("final busy", {bus.I_BUSY_WAIT, bus.D_BUSY_WAIT}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified 128-bit-block main memory between the instruction cache (read-only) and the data cache (read/write).
- Sits between `ins_cache_memory` / `data_cache_memory` and a single `data_memory` instance, replacing the two separate main memories.
- Presents each cache with a standard main-memory port: READ/WRITE plus BUSY_WAIT. Each cache stays unaware of the other.

Parameters:
- ADDR_W, 28, block address width (byte address >> 4).
- DATA_W, 128, block width in bits.

Ports:
- CLK  in  1  system clock, all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- I_READ  in  1  I-cache block read request.
- I_ADDRESS  in  ADDR_W  I-cache block address.
- I_READ_DATA  out  DATA_W  block returned to I-cache.
- I_BUSY_WAIT  out  1  I-cache stall.
- D_READ  in  1  D-cache block read request.
- D_WRITE  in  1  D-cache block write-back request.
- D_ADDRESS  in  ADDR_W  D-cache block address.
- D_WRITE_DATA  in  DATA_W  write-back block.
- D_READ_DATA  out  DATA_W  block returned to D-cache.
- D_BUSY_WAIT  out  1  D-cache stall.
- MEM_READ  out  1  to main memory.
- MEM_WRITE  out  1  to main memory.
- MEM_ADDRESS  out  ADDR_W  to main memory.
- MEM_WRITE_DATA  out  DATA_W  to main memory.
- MEM_READ_DATA  in  DATA_W  from main memory.
- MEM_BUSY_WAIT  in  1  memory busy; asserted while request held and access incomplete.

Behaviour:
- Reset:
  - The FSM enters IDLE; MEM_READ, MEM_WRITE, busy_seen and the latched address/data/response registers are all 0.
  - last_grant resets to I, so D wins the first tie.
  - This holds for reset asserted mid-access: the memory request drops in the same edge, and the memory must be reset alongside.
- Requester busy:
  - Combinational: `X_BUSY_WAIT = X_req && !(state==RESP && owner==X)`.
  - `I_req = I_READ`; `D_req = D_READ | D_WRITE`.
- D op decode:
  - If D_WRITE is high, the op is a write and D_READ is ignored, even if both are high.
- IDLE state:
  - At a rising edge with exactly one requester pending, grant that requester.
  - If both are pending, grant the one that is not last_grant.
  - On grant: latch owner, op, address and write data (D only); set last_grant = owner; go to GRANT.
  - No request pending: stay in IDLE.
- GRANT state:
  - MEM_READ/MEM_WRITE/MEM_ADDRESS/MEM_WRITE_DATA are driven from the latched registers only; requester input changes are ignored.
  - busy_seen is set at the first edge that samples MEM_BUSY_WAIT=1.
  - At an edge with busy_seen=1 and MEM_BUSY_WAIT=0: latch MEM_READ_DATA into the owner's response register (reads only) and go to RESP.
- RESP state (exactly 1 cycle):
  - MEM_READ = MEM_WRITE = 0.
  - The owner's BUSY_WAIT is low and its READ_DATA holds the latched block.
  - The owner must complete or drop its request at this edge.
  - Clear busy_seen; go to IDLE.
- READ_DATA outputs hold their last latched value outside RESP; each requester has its own register.
- Latency:
  - Uncontended access = 1 (IDLE→GRANT) + memory cycles + 1 (RESP).
  - A losing requester waits for the full owner transaction, then is granted at the next IDLE edge.
- Fairness:
  - Strict alternation under continuous contention, so neither requester waits more than one transaction.
- A request withdrawn while waiting (not granted) is dropped silently.
- A request withdrawn mid-GRANT has no effect; the access completes and the response is discarded.

Test Plan:
- I-only read:
  - Stimulus: I_READ=1, I_ADDRESS=0x0000004; memory latency 5 cycles, returns 0xDEAD…0001.
  - Required response: MEM_READ high 1 cycle after request; I_BUSY_WAIT low for exactly 1 cycle (RESP) with I_READ_DATA=0xDEAD…0001; D_BUSY_WAIT stays 0.
- D write-back:
  - Stimulus: D_WRITE=1, D_ADDRESS=0x0000010, D_WRITE_DATA=0x1234…ABCD.
  - Required response: MEM_WRITE=1 with that address/data until memory completes; D_BUSY_WAIT drops 1 cycle; MEM_READ never asserted.
- Simultaneous requests after reset:
  - Stimulus: I and D both request from reset.
  - Required response: D granted first; I_BUSY_WAIT held high throughout; I granted on the edge after D's RESP.
- Continuous contention:
  - Stimulus: D reissues immediately after its RESP while I is pending.
  - Required response: I is served next; order D, I, D, I over 4 transactions.
- D_READ and D_WRITE both high:
  - Required response: MEM_WRITE=1, MEM_READ=0.
- Reset mid-GRANT:
  - Stimulus: RESET asserted 2 cycles into a D read.
  - Required response: next edge state=IDLE, MEM_READ=0, busy_seen=0; after release with both pending, D is granted first.
